// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central pipeline controller for the 5-stage MIPS core. Produces one enable
// and one bubble-insert (flush) per pipeline state element for:
//   - load-use interlock (LU_SLOTS stall cycles per hazard)
//   - taken-branch squash of IF2ID / ID2EX
//   - multi-cycle EX operations (mc_cycles-1 stall cycles, the accept cycle
//     included)
//   - interrupt drain of the front end followed by a one-cycle irq_take
//
// Outputs are the combinational decode of the registered state and the
// current-cycle inputs, so a hazard is acted on in the cycle it is seen.
// While rst_n is low all outputs sit at their reset values.
//
// Optional macro PIPE_FWD_EN:
//   defined   - operand forwarding unit present (fwd_a_sel / fwd_b_sel)
//   undefined - selects tied to 2'b00; any EX/MEM destination matching a
//               used ID source stalls ID for one (re-evaluated) cycle.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_rs/id_rt, id_uses_*     ID-stage sources and their valid bits
//   ex_rs/ex_rt/ex_rd          EX-stage sources and destination
//   ex_regwrite, ex_memread    EX-stage control
//   mem_rd/mem_regwrite        MEM-stage destination and write qualifier
//   wb_rd/wb_regwrite          WB-stage destination and write qualifier
//   ex_branch_taken            branch/jump resolved taken in EX
//   mc_start, mc_cycles        multi-cycle op entering EX and its latency
//   irq                        level interrupt request
//   stage_en, stage_flush      per-stage enable / bubble insert
//   fwd_a_sel, fwd_b_sel       ALU operand source (00 RF, 01 EX2MEM, 10 MEM2WB)
//   irq_take                   one-cycle pulse: load vector, save EPC
//   epc_from_branch            with irq_take: EPC is the branch target
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int NSTAGE   = 5,
  parameter int REG_AW   = 5,
  parameter int LU_SLOTS = 1,
  parameter int MC_CW    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic              ex_branch_taken,
  input  logic              mc_start,
  input  logic [MC_CW-1:0]  mc_cycles,
  input  logic              irq,
  output logic [NSTAGE-1:0] stage_en,
  output logic [NSTAGE-1:0] stage_flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              irq_take,
  output logic              epc_from_branch
);

  localparam int CW_MC = (MC_CW > 3) ? MC_CW : 3;
  localparam int CW_NS = $clog2(NSTAGE);
  localparam int CW    = (CW_MC > CW_NS) ? CW_MC : CW_NS;

  localparam logic [CW-1:0]     CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_LU    = 3'd1,
    ST_MC    = 3'd2,
    ST_DRAIN = 3'd3,
    ST_TAKE  = 3'd4
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_epc_br;

  logic          w_lu_haz;
  logic          w_raw_haz;
  logic          w_mc_go;
  logic [CW-1:0] w_mc_load;
  logic          w_unused;

  // True when a non-zero destination rd is read by the ID instruction.
  function automatic logic id_reads(input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] rs, input logic use_rs,
                                    input logic [REG_AW-1:0] rt, input logic use_rt);
    return (rd != REG_ZERO) && ((use_rs && (rs == rd)) || (use_rt && (rt == rd)));
  endfunction

  // Forwarding source for one EX operand; EX2MEM beats MEM2WB, r0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
    logic [1:0] sel;
    if (mem_regwrite && (mem_rd != REG_ZERO) && (mem_rd == src)) begin
      sel = 2'b01;
    end else if (wb_regwrite && (wb_rd != REG_ZERO) && (wb_rd == src)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign w_lu_haz  = ex_memread && id_reads(ex_rd, id_rs, id_uses_rs, id_rt, id_uses_rt);
  assign w_mc_go   = mc_start && (mc_cycles >= MC_CW'(2));
  // Extra MC_BUSY cycles after the accept cycle; zero means a 2-cycle op
  // is fully covered by the accept-cycle stall.
  assign w_mc_load = CW'(mc_cycles) - CW'(2);

`ifdef PIPE_FWD_EN
  assign w_raw_haz = 1'b0;
  assign w_unused  = ex_regwrite;
`else
  // Without forwarding every in-flight writer of a used source interlocks ID.
  assign w_raw_haz = (ex_regwrite  && id_reads(ex_rd,  id_rs, id_uses_rs, id_rt, id_uses_rt)) ||
                     (mem_regwrite && id_reads(mem_rd, id_rs, id_uses_rs, id_rt, id_uses_rt));
  assign w_unused  = ^{ex_rs, ex_rt, wb_rd, wb_regwrite};
`endif

  // Controller state, shared countdown and sticky branch-during-drain flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_cnt    <= CNT_ZERO;
      r_epc_br <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (ex_branch_taken) begin
            r_state <= ST_RUN;
          end else if (w_mc_go) begin
            if (w_mc_load != CNT_ZERO) begin
              r_state <= ST_MC;
              r_cnt   <= w_mc_load;
            end
          end else if (w_lu_haz) begin
            if (LU_SLOTS > 1) begin
              r_state <= ST_LU;
              r_cnt   <= CW'(LU_SLOTS - 1);
            end
          end else if (w_raw_haz) begin
            r_state <= ST_RUN;
          end else if (irq) begin
            r_state <= ST_DRAIN;
            r_cnt   <= CW'(NSTAGE - 3);
          end
        end
        ST_LU, ST_MC: begin
          // The counter holds the stall cycles left including this one.
          if (r_cnt <= CNT_ONE) begin
            r_state <= ST_RUN;
            r_cnt   <= CNT_ZERO;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_DRAIN: begin
          if (ex_branch_taken) begin
            r_epc_br <= 1'b1;
          end
          if (r_cnt <= CNT_ONE) begin
            r_state <= ST_TAKE;
            r_cnt   <= CNT_ZERO;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_TAKE: begin
          r_state  <= ST_RUN;
          r_epc_br <= 1'b0;
        end
        default: begin
          r_state  <= ST_RUN;
          r_cnt    <= CNT_ZERO;
          r_epc_br <= 1'b0;
        end
      endcase
    end
  end

  // Enable/flush/irq decode from the current state and this cycle's inputs.
  always_comb begin
    stage_en        = {NSTAGE{1'b1}};
    stage_flush     = {NSTAGE{1'b0}};
    irq_take        = 1'b0;
    epc_from_branch = 1'b0;
    if (!rst_n) begin
      stage_en = {NSTAGE{1'b1}};
    end else begin
      case (r_state)
        ST_RUN: begin
          if (ex_branch_taken) begin
            stage_flush[1] = 1'b1;
            stage_flush[2] = 1'b1;
          end else if (w_mc_go) begin
            stage_en[2:0]  = 3'b000;
            stage_flush[3] = 1'b1;
          end else if (w_lu_haz || w_raw_haz) begin
            stage_en[1:0]  = 2'b00;
            stage_flush[2] = 1'b1;
          end else if (irq) begin
            stage_flush[1] = 1'b1;
          end else begin
            stage_flush = {NSTAGE{1'b0}};
          end
        end
        ST_LU: begin
          stage_en[1:0]  = 2'b00;
          stage_flush[2] = 1'b1;
        end
        ST_MC: begin
          stage_en[2:0]  = 3'b000;
          stage_flush[3] = 1'b1;
        end
        ST_DRAIN: begin
          stage_flush[1] = 1'b1;
          if (ex_branch_taken) begin
            stage_flush[2] = 1'b1;
          end else begin
            stage_flush[2] = 1'b0;
          end
        end
        ST_TAKE: begin
          irq_take        = 1'b1;
          epc_from_branch = r_epc_br;
          stage_flush[1]  = 1'b1;
          stage_flush[2]  = 1'b1;
        end
        default: begin
          stage_en = {NSTAGE{1'b1}};
        end
      endcase
    end
  end

  // Operand forwarding selects.
  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
`ifdef PIPE_FWD_EN
    if (rst_n) begin
      fwd_a_sel = fwd_sel(ex_rs);
      fwd_b_sel = fwd_sel(ex_rt);
    end else begin
      fwd_a_sel = 2'b00;
      fwd_b_sel = 2'b00;
    end
`endif
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl (default parameters: NSTAGE=5, LU_SLOTS=1).
module tb_pipe_hazard_ctrl;

  localparam int NSTAGE   = 5;
  localparam int LU_SLOTS = 1;
`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs, id_uses_rt, ex_regwrite, ex_memread;
  logic       mem_regwrite, wb_regwrite, ex_branch_taken, mc_start, irq;
  logic [5:0] mc_cycles;
  logic [4:0] stage_en, stage_flush;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       irq_take, epc_from_branch;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .ex_branch_taken(ex_branch_taken), .mc_start(mc_start), .mc_cycles(mc_cycles),
    .irq(irq),
    .stage_en(stage_en), .stage_flush(stage_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .irq_take(irq_take), .epc_from_branch(epc_from_branch)
  );

  typedef struct {
    string      name;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       ur, ut, ex_rw, ex_mr, mem_rw, wb_rw, br, mcs;
    logic [5:0] mcc;
    logic [4:0] en, fl;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t idle_vec(input string nm);
    vec_t v;
    v.name = nm;
    v.id_rs = 5'd0; v.id_rt = 5'd0; v.ex_rs = 5'd0; v.ex_rt = 5'd0;
    v.ex_rd = 5'd0; v.mem_rd = 5'd0; v.wb_rd = 5'd0;
    v.ur = 1'b0; v.ut = 1'b0; v.ex_rw = 1'b0; v.ex_mr = 1'b0;
    v.mem_rw = 1'b0; v.wb_rw = 1'b0; v.br = 1'b0; v.mcs = 1'b0;
    v.mcc = 6'd0;
    v.en = 5'b11111; v.fl = 5'b00000; v.fa = 2'b00; v.fb = 2'b00;
    return v;
  endfunction

  task automatic set_idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0;
    mem_rd = 5'd0; wb_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    mem_regwrite = 1'b0; wb_regwrite = 1'b0; ex_branch_taken = 1'b0;
    mc_start = 1'b0; mc_cycles = 6'd0; irq = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    id_rs = v.id_rs; id_rt = v.id_rt; ex_rs = v.ex_rs; ex_rt = v.ex_rt;
    ex_rd = v.ex_rd; mem_rd = v.mem_rd; wb_rd = v.wb_rd;
    id_uses_rs = v.ur; id_uses_rt = v.ut; ex_regwrite = v.ex_rw; ex_memread = v.ex_mr;
    mem_regwrite = v.mem_rw; wb_regwrite = v.wb_rw; ex_branch_taken = v.br;
    mc_start = v.mcs; mc_cycles = v.mcc; irq = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [4:0] een, input logic [4:0] efl,
                     input logic et, input logic ee, input logic [1:0] efa,
                     input logic [1:0] efb);
    n_chk++;
    if (stage_en !== een || stage_flush !== efl || irq_take !== et ||
        epc_from_branch !== ee || fwd_a_sel !== efa || fwd_b_sel !== efb) begin
      n_fail++;
      $display("FAIL %s @%0t: got en=%b fl=%b take=%b epc=%b fa=%b fb=%b, expected en=%b fl=%b take=%b epc=%b fa=%b fb=%b",
               nm, $time, stage_en, stage_flush, irq_take, epc_from_branch, fwd_a_sel,
               fwd_b_sel, een, efl, et, ee, efa, efb);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int lu_left = 0, mc_left = 0, drain_left = 0;
  bit take_pend = 1'b0, epc_flag = 1'b0;

  function automatic logic reads(input logic [4:0] rd);
    return (rd != 5'd0) && ((id_uses_rs && id_rs == rd) || (id_uses_rt && id_rt == rd));
  endfunction

  function automatic logic [1:0] fwd_model(input logic [4:0] src);
    if (!FWD) return 2'b00;
    if (mem_regwrite && mem_rd != 5'd0 && mem_rd == src) return 2'b01;
    if (wb_regwrite && wb_rd != 5'd0 && wb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_chk();
    logic [4:0] een, efl;
    logic       et, ee, lu, raw;
    een = 5'b11111; efl = 5'b00000; et = 1'b0; ee = 1'b0;
    lu  = ex_memread && reads(ex_rd);
    raw = !FWD && ((ex_regwrite && reads(ex_rd)) || (mem_regwrite && reads(mem_rd)));
    if (take_pend) begin
      et = 1'b1; efl = 5'b00110; ee = epc_flag;
      take_pend = 1'b0; epc_flag = 1'b0;
    end else if (drain_left > 0) begin
      efl[1] = 1'b1;
      if (ex_branch_taken) begin efl[2] = 1'b1; epc_flag = 1'b1; end
      drain_left--;
      if (drain_left == 0) take_pend = 1'b1;
    end else if (mc_left > 0) begin
      een = 5'b11000; efl = 5'b01000; mc_left--;
    end else if (lu_left > 0) begin
      een = 5'b11100; efl = 5'b00100; lu_left--;
    end else if (ex_branch_taken) begin
      efl = 5'b00110;
    end else if (mc_start && mc_cycles >= 6'd2) begin
      een = 5'b11000; efl = 5'b01000; mc_left = int'(mc_cycles) - 2;
    end else if (lu || raw) begin
      een = 5'b11100; efl = 5'b00100;
      if (lu) lu_left = LU_SLOTS - 1;
    end else if (irq) begin
      efl = 5'b00010; drain_left = NSTAGE - 3;
    end
    chk("random", een, efl, et, ee, fwd_model(ex_rs), fwd_model(ex_rt));
  endtask

  // One hand-sequence step: inputs already set at negedge; compare 1 time unit later.
  task automatic step(input string nm, input logic [4:0] een, input logic [4:0] efl,
                      input logic et, input logic ee);
    #1;
    chk(nm, een, efl, et, ee, 2'b00, 2'b00);
  endtask

  initial begin
    vec_t v;

    // ---------------- vector table ----------------
    tbl.push_back(idle_vec("idle"));
    v = idle_vec("lu_rs"); v.ex_mr = 1'b1; v.ex_rw = 1'b1; v.ex_rd = 5'd8;
    v.id_rs = 5'd8; v.ur = 1'b1; v.en = 5'b11100; v.fl = 5'b00100; tbl.push_back(v);
    tbl.push_back(idle_vec("lu_release"));
    v = idle_vec("lu_rt"); v.ex_mr = 1'b1; v.ex_rd = 5'd8; v.id_rs = 5'd9; v.ur = 1'b1;
    v.id_rt = 5'd8; v.ut = 1'b1; v.en = 5'b11100; v.fl = 5'b00100; tbl.push_back(v);
    v = idle_vec("lu_unused_src"); v.ex_mr = 1'b1; v.ex_rw = 1'b1; v.ex_rd = 5'd8;
    v.id_rs = 5'd8; tbl.push_back(v);
    v = idle_vec("lu_r0"); v.ex_mr = 1'b1; v.ex_rw = 1'b1; v.ex_rd = 5'd0;
    v.id_rs = 5'd0; v.ur = 1'b1; tbl.push_back(v);
    v = idle_vec("branch_and_lu"); v.br = 1'b1; v.ex_mr = 1'b1; v.ex_rd = 5'd8;
    v.id_rs = 5'd8; v.ur = 1'b1; v.fl = 5'b00110; tbl.push_back(v);
    v = idle_vec("mc_cycles_1"); v.mcs = 1'b1; v.mcc = 6'd1; tbl.push_back(v);
    v = idle_vec("mc_cycles_0"); v.mcs = 1'b1; v.mcc = 6'd0; tbl.push_back(v);
    v = idle_vec("mc_cycles_2"); v.mcs = 1'b1; v.mcc = 6'd2;
    v.en = 5'b11000; v.fl = 5'b01000; tbl.push_back(v);
    tbl.push_back(idle_vec("mc2_release"));
    v = idle_vec("raw_ex"); v.ex_rw = 1'b1; v.ex_rd = 5'd5; v.id_rs = 5'd5; v.ur = 1'b1;
    v.en = FWD ? 5'b11111 : 5'b11100; v.fl = FWD ? 5'b00000 : 5'b00100; tbl.push_back(v);
    v = idle_vec("raw_mem"); v.mem_rw = 1'b1; v.mem_rd = 5'd6; v.id_rt = 5'd6; v.ut = 1'b1;
    v.en = FWD ? 5'b11111 : 5'b11100; v.fl = FWD ? 5'b00000 : 5'b00100; tbl.push_back(v);
    v = idle_vec("fwd_both"); v.mem_rw = 1'b1; v.wb_rw = 1'b1; v.mem_rd = 5'd3;
    v.wb_rd = 5'd3; v.ex_rs = 5'd3; v.fa = FWD ? 2'b01 : 2'b00; tbl.push_back(v);
    v = idle_vec("fwd_rs0"); v.mem_rw = 1'b1; v.wb_rw = 1'b1; v.mem_rd = 5'd3;
    v.wb_rd = 5'd3; v.ex_rs = 5'd0; tbl.push_back(v);
    v = idle_vec("fwd_wb_b"); v.mem_rw = 1'b1; v.mem_rd = 5'd2; v.wb_rw = 1'b1;
    v.wb_rd = 5'd7; v.ex_rt = 5'd7; v.fb = FWD ? 2'b10 : 2'b00; tbl.push_back(v);
    v = idle_vec("fwd_r0"); v.mem_rw = 1'b1; v.mem_rd = 5'd0; v.wb_rw = 1'b1;
    v.wb_rd = 5'd0; v.ex_rs = 5'd0; v.ex_rt = 5'd0; tbl.push_back(v);

    // ---------------- reset: hazard inputs must not leak through ----------------
    rst_n = 1'b0;
    set_idle();
    ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1; irq = 1'b1;
    @(negedge clk); step("reset_values", 5'b11111, 5'b00000, 1'b0, 1'b0);
    @(negedge clk); set_idle(); rst_n = 1'b1;
    step("post_reset", 5'b11111, 5'b00000, 1'b0, 1'b0);

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      chk(tbl[i].name, tbl[i].en, tbl[i].fl, 1'b0, 1'b0, tbl[i].fa, tbl[i].fb);
    end

    // ---------------- multi-cycle op, irq held pending ----------------
    @(negedge clk); set_idle(); mc_start = 1'b1; mc_cycles = 6'd4;
    step("mc4_accept", 5'b11000, 5'b01000, 1'b0, 1'b0);
    @(negedge clk); set_idle(); ex_branch_taken = 1'b1; irq = 1'b1;
    step("mc4_busy1_br_ignored", 5'b11000, 5'b01000, 1'b0, 1'b0);
    @(negedge clk); set_idle(); irq = 1'b1;
    step("mc4_busy2", 5'b11000, 5'b01000, 1'b0, 1'b0);
    @(negedge clk); step("irq_accept_after_mc", 5'b11111, 5'b00010, 1'b0, 1'b0);
    @(negedge clk); irq = 1'b0; step("drain1", 5'b11111, 5'b00010, 1'b0, 1'b0);
    @(negedge clk); step("drain2", 5'b11111, 5'b00010, 1'b0, 1'b0);
    @(negedge clk); step("take_no_branch", 5'b11111, 5'b00110, 1'b1, 1'b0);
    @(negedge clk); step("after_take_idle", 5'b11111, 5'b00000, 1'b0, 1'b0);

    // ---------------- irq with branch during drain ----------------
    @(negedge clk); irq = 1'b1; step("irq_accept", 5'b11111, 5'b00010, 1'b0, 1'b0);
    @(negedge clk); ex_branch_taken = 1'b1;
    step("drain_branch", 5'b11111, 5'b00110, 1'b0, 1'b0);
    @(negedge clk); ex_branch_taken = 1'b0;
    step("drain_after_branch", 5'b11111, 5'b00010, 1'b0, 1'b0);
    @(negedge clk); step("take_epc_branch", 5'b11111, 5'b00110, 1'b1, 1'b1);
    @(negedge clk); step("irq_reaccept_next", 5'b11111, 5'b00010, 1'b0, 1'b0);
    @(negedge clk); irq = 1'b0; step("drain1_b", 5'b11111, 5'b00010, 1'b0, 1'b0);
    @(negedge clk); step("drain2_b", 5'b11111, 5'b00010, 1'b0, 1'b0);
    @(negedge clk); step("take_epc_cleared", 5'b11111, 5'b00110, 1'b1, 1'b0);

    // ---------------- reset dropped mid MC_BUSY ----------------
    @(negedge clk); set_idle(); mc_start = 1'b1; mc_cycles = 6'd6;
    step("mc6_accept", 5'b11000, 5'b01000, 1'b0, 1'b0);
    @(negedge clk); set_idle(); step("mc6_busy", 5'b11000, 5'b01000, 1'b0, 1'b0);
    #1; rst_n = 1'b0; ex_memread = 1'b1; ex_rd = 5'd4; id_rt = 5'd4; id_uses_rt = 1'b1;
    step("reset_mid_mc", 5'b11111, 5'b00000, 1'b0, 1'b0);
    @(negedge clk); set_idle(); rst_n = 1'b1;
    step("release_run", 5'b11111, 5'b00000, 1'b0, 1'b0);
    @(negedge clk); step("release_run2", 5'b11111, 5'b00000, 1'b0, 1'b0);

    // ---------------- randomized run against the reference model ----------------
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom_range(0, 1)); id_uses_rt = 1'($urandom_range(0, 1));
      ex_regwrite = 1'($urandom_range(0, 1)); ex_memread = ($urandom_range(0, 2) == 0);
      mem_regwrite = 1'($urandom_range(0, 1)); wb_regwrite = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mc_start = ($urandom_range(0, 7) == 0); mc_cycles = 6'($urandom_range(0, 6));
      irq = ($urandom_range(0, 9) == 0);
      #1;
      model_chk();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
